// File: rtl/fpu_driver.sv
// Host-to-FPU command driver: widens half-precision operands, issues four start pulses, captures the completion.
// Optional watchdog on the WAIT state is built when FPU_DRIVER_WATCHDOG_EN is defined.
module fpu_driver #(
  parameter int unsigned TMO_CYCLES = 64,
  parameter logic [15:0] ERR_CODE   = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic        fpu_start,
  output logic [17:0] fpu_a,
  output logic [17:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic        fpu_ready,
  input  logic        fpu_error,
  input  logic [15:0] fpu_result,
  output logic        res_valid,
  input  logic        res_ack,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic        res_tmo
);

  typedef enum logic [3:0] {IDLE, P1, G1, P2, G2, P3, G3, P4, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [17:0] fpu_a_q, fpu_a_d;
  logic [17:0] fpu_b_q, fpu_b_d;
  logic [1:0]  fpu_op_q, fpu_op_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
`ifdef FPU_DRIVER_WATCHDOG_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TMO_CYCLES);
  logic [7:0]  wdog_q, wdog_d;
  logic        res_tmo_q, res_tmo_d;
`endif

  // Hidden bit is implied by a nonzero exponent; subnormals and zero keep it clear.
  function automatic logic [17:0] extend_half(input logic [15:0] h);
    return {h[15], h[14:10], 1'b0, |h[14:10], h[9:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    fpu_op_d   = fpu_op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef FPU_DRIVER_WATCHDOG_EN
    wdog_d     = wdog_q;
    res_tmo_d  = res_tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          fpu_a_d  = extend_half(cmd_a);
          fpu_b_d  = extend_half(cmd_b);
          fpu_op_d = cmd_op;
          state_d  = P1;
        end
      end
      P1: state_d = G1;
      G1: state_d = P2;
      P2: state_d = G2;
      G2: state_d = P3;
      P3: state_d = G3;
      G3: state_d = P4;
      P4: begin
        state_d = WAIT;
`ifdef FPU_DRIVER_WATCHDOG_EN
        wdog_d  = 8'd0;
`endif
      end
      // Error beats ready; a strobe in the timeout cycle beats the timeout.
      WAIT: begin
        if (fpu_error) begin
          res_data_d = ERR_CODE;
          res_err_d  = 1'b1;
`ifdef FPU_DRIVER_WATCHDOG_EN
          res_tmo_d  = 1'b0;
`endif
          state_d    = DONE;
        end else if (fpu_ready) begin
          res_data_d = fpu_result;
          res_err_d  = 1'b0;
`ifdef FPU_DRIVER_WATCHDOG_EN
          res_tmo_d  = 1'b0;
`endif
          state_d    = DONE;
        end
`ifdef FPU_DRIVER_WATCHDOG_EN
        else if (wdog_q == TMO_LIMIT) begin
          res_data_d = ERR_CODE;
          res_err_d  = 1'b1;
          res_tmo_d  = 1'b1;
          state_d    = DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      DONE: begin
        if (res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
`ifdef FPU_DRIVER_WATCHDOG_EN
      wdog_q     <= '0;
      res_tmo_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
`ifdef FPU_DRIVER_WATCHDOG_EN
      wdog_q     <= wdog_d;
      res_tmo_q  <= res_tmo_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign fpu_start = (state_q == P1) || (state_q == P2) || (state_q == P3) || (state_q == P4);
  assign res_valid = (state_q == DONE);
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
`ifdef FPU_DRIVER_WATCHDOG_EN
  assign res_tmo   = res_tmo_q;
`else
  assign res_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_driver.sv
// Scoreboard bench for fpu_driver: directed commands push expected completions, a monitor checks each res_valid rise.
// Follows FPU_DRIVER_WATCHDOG_EN the same way the design does.
module tb_fpu_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic        fpu_start;
  logic [17:0] fpu_a;
  logic [17:0] fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_ready = 1'b0;
  logic        fpu_error = 1'b0;
  logic [15:0] fpu_result = '0;
  logic        res_valid;
  logic        res_ack = 1'b0;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_tmo;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        tmo;
    logic [17:0] a;
    logic [17:0] b;
    logic [1:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic valid_prev = 1'b0;

  fpu_driver #(.TMO_CYCLES(64), .ERR_CODE(16'h7E00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_ready(fpu_ready), .fpu_error(fpu_error), .fpu_result(fpu_result),
    .res_valid(res_valid), .res_ack(res_ack),
    .res_data(res_data), .res_err(res_err), .res_tmo(res_tmo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  // Monitor: every new res_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      valid_prev = 1'b0;
    end else begin
      if (res_valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("res_data", res_data, e.data);
          checkOutput("res_err", res_err, e.err);
          checkOutput("res_tmo", res_tmo, e.tmo);
          checkOutput("fpu_a", fpu_a, e.a);
          checkOutput("fpu_b", fpu_b, e.b);
          checkOutput("fpu_op", fpu_op, e.op);
        end
      end
      valid_prev = res_valid;
    end
  end

  // Presents a command and returns just after the accepting clock edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int n = 0;
    @(negedge clk);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Offset k is the k-th negedge after the accept edge; pulses expected at even k.
  task automatic checkPulses(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fpu_start_k%0d", k), fpu_start, (k % 2 == 0) ? 1 : 0);
    end
  endtask

  // Called right after the P4 check; strobes after 'delay' extra WAIT cycles.
  task automatic respond(input int delay, input logic rdy, input logic err, input logic [15:0] res);
    @(negedge clk);
    repeat (delay) @(negedge clk);
    fpu_ready = rdy;
    fpu_error = err;
    fpu_result = res;
    @(negedge clk);
    fpu_ready = 1'b0;
    fpu_error = 1'b0;
  endtask

  task automatic waitValid(input string name, input int max_cycles);
    int n = 0;
    while (!res_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, res_valid, 1);
  endtask

  task automatic ackResult(input int hold);
    repeat (hold) @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    int pulses;
    int seen;

    // Reset state
    #12;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_fpu_start", fpu_start, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_fpu_a", fpu_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_rst", cmd_ready, 1);

    // Normal add
    applyStimulus(16'h3C00, 16'h4000, 2'd0);
    checkPulses(0, 6);
    exp_q.push_back('{16'h4200, 1'b0, 1'b0, 18'h0F400, 18'h10400, 2'd0});
    respond(0, 1'b1, 1'b0, 16'h4200);
    waitValid("valid_add", 5);
    ackResult(1);
    checkOutput("res_data_hold", res_data, 16'h4200);

    // Subnormal and negative zero, late ready; early strobe during gaps is ignored
    applyStimulus(16'h0001, 16'h8000, 2'd2);
    checkPulses(0, 2);
    fpu_ready = 1'b1;
    fpu_result = 16'hDEAD;
    checkPulses(3, 4);
    fpu_ready = 1'b0;
    checkPulses(5, 6);
    exp_q.push_back('{16'h8000, 1'b0, 1'b0, 18'h00001, 18'h20000, 2'd2});
    respond(3, 1'b1, 1'b0, 16'h8000);
    waitValid("valid_sub", 5);
    ackResult(0);

    // Error and ready together
    applyStimulus(16'hC500, 16'h7BFF, 2'd3);
    checkPulses(0, 6);
    exp_q.push_back('{16'h7E00, 1'b1, 1'b0, 18'h31500, 18'h1E7FF, 2'd3});
    respond(0, 1'b1, 1'b1, 16'h1234);
    waitValid("valid_err", 5);
    ackResult(0);

    // Backpressure with a command held pending throughout
    applyStimulus(16'h4400, 16'h3800, 2'd1);
    cmd_a = 16'h5000;
    cmd_b = 16'h5000;
    cmd_op = 2'd0;
    cmd_valid = 1'b1;
    checkPulses(0, 6);
    exp_q.push_back('{16'h4000, 1'b0, 1'b0, 18'h11400, 18'h0E400, 2'd1});
    respond(0, 1'b1, 1'b0, 16'h4000);
    waitValid("valid_bp", 5);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_res_valid", res_valid, 1);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_fpu_start", fpu_start, 0);
      @(negedge clk);
    end
    res_ack = 1'b1;
    @(posedge clk);
    #1 res_ack = 1'b0;
    @(negedge clk);
    checkOutput("ack_cycle_not_accepted", fpu_start, 0);
    checkOutput("cmd_ready_after_ack", cmd_ready, 1);
    @(negedge clk);
    checkOutput("accept_two_after_ack", fpu_start, 1);
    cmd_valid = 1'b0;
    checkPulses(1, 6);
    exp_q.push_back('{16'h5400, 1'b0, 1'b0, 18'h14400, 18'h14400, 2'd0});
    respond(1, 1'b1, 1'b0, 16'h5400);
    waitValid("valid_bp2", 5);
    ackResult(0);

    // Reset after the second start pulse
    applyStimulus(16'h4000, 16'h4000, 2'd2);
    checkPulses(0, 2);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_fpu_start", fpu_start, 0);
    checkOutput("mid_rst_fpu_a", fpu_a, 0);
    checkOutput("mid_rst_fpu_op", fpu_op, 0);
    checkOutput("mid_rst_res_data", res_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fpu_start) pulses++;
    end
    checkOutput("no_pulse_after_rst", pulses, 0);

    // Normal command after the abandoned one
    applyStimulus(16'h0000, 16'h0400, 2'd1);
    checkPulses(0, 6);
    exp_q.push_back('{16'h8400, 1'b0, 1'b0, 18'h00000, 18'h01400, 2'd1});
    respond(0, 1'b1, 1'b0, 16'h8400);
    waitValid("valid_post_rst", 5);
    ackResult(0);

    // Silent FPU
    applyStimulus(16'h3C00, 16'h3C00, 2'd0);
    checkPulses(0, 6);
`ifdef FPU_DRIVER_WATCHDOG_EN
    exp_q.push_back('{16'h7E00, 1'b1, 1'b1, 18'h0F400, 18'h0F400, 2'd0});
    @(negedge clk);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_latency", n, 65);
    ackResult(0);
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (res_valid || res_tmo) seen++;
    end
    checkOutput("no_timeout_without_wdog", seen, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_recover", cmd_ready, 1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
